// File: rtl/reduce_xcel_pkg.sv
// Shared types for the streaming reduction accelerator: operation select,
// control-FSM states and the per-mode accumulator identity.
package reduce_xcel_pkg;

    typedef enum logic [1:0] {
        SUM = 2'd0,
        MIN = 2'd1,
        MAX = 2'd2,
        XOR = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    // Every identity is either all-zeros or all-ones, so the fill bit is
    // enough to build it at any data width.
    function automatic logic identity_fill(input mode_e mode);
        return (mode == MIN);
    endfunction

endpackage

// File: rtl/reduce_alu.sv
// One reduction step: combines the accumulator with a memory word.
// Define REDUCE_XCEL_SAT_EN to make sum mode saturate instead of wrap.
module reduce_alu
    import reduce_xcel_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] data_i,
    input  mode_e             mode_i,
    output logic [DATA_W-1:0] acc_next_o,
    output logic              carry_o
);

    logic [DATA_W:0] sum_w;

    assign sum_w = {1'b0, acc_i} + {1'b0, data_i};

    always_comb begin
        acc_next_o = acc_i;
        carry_o    = 1'b0;
        case (mode_i)
            SUM: begin
                carry_o = sum_w[DATA_W];
`ifdef REDUCE_XCEL_SAT_EN
                // Once saturated, any non-zero add carries again, so the
                // all-ones value is naturally sticky for the rest of the job.
                acc_next_o = sum_w[DATA_W] ? {DATA_W{1'b1}} : sum_w[DATA_W-1:0];
`else
                acc_next_o = sum_w[DATA_W-1:0];
`endif
            end
            MIN:     acc_next_o = (data_i < acc_i) ? data_i : acc_i;
            MAX:     acc_next_o = (data_i > acc_i) ? data_i : acc_i;
            XOR:     acc_next_o = acc_i ^ data_i;
            default: acc_next_o = acc_i;
        endcase
    end

endmodule

// File: rtl/reduce_xcel.sv
// Streaming reduction accelerator: control FSM, address/count registers and
// accumulator. Optional saturating sum via REDUCE_XCEL_SAT_EN (see reduce_alu).
module reduce_xcel
    import reduce_xcel_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int SIZE_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go_val,
    output logic              go_rdy,
    input  logic [ADDR_W-1:0] go_base,
    input  logic [SIZE_W-1:0] go_size,
    input  logic [1:0]        go_mode,
    output logic              mem_reqval,
    input  logic              mem_reqrdy,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_respval,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              result_val,
    input  logic              result_rdy,
    output logic [DATA_W-1:0] result,
    output logic              ovf,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

    state_e            state_q;
    mode_e             mode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [SIZE_W-1:0] remaining_q;
    logic [DATA_W-1:0] acc_q;
    logic              ovf_q;

    logic [DATA_W-1:0] acc_d;
    logic              carry_d;

    reduce_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .acc_i      (acc_q),
        .data_i     (mem_rdata),
        .mode_i     (mode_q),
        .acc_next_o (acc_d),
        .carry_o    (carry_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= SUM;
            addr_q      <= '0;
            remaining_q <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go_val) begin
                        addr_q      <= go_base;
                        remaining_q <= go_size;
                        mode_q      <= mode_e'(go_mode);
                        acc_q       <= {DATA_W{identity_fill(mode_e'(go_mode))}};
                        ovf_q       <= 1'b0;
                        state_q     <= (go_size == '0) ? DONE : REQ;
                    end
                end
                REQ: begin
                    if (mem_reqrdy) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (mem_respval) begin
                        acc_q       <= acc_d;
                        ovf_q       <= ovf_q | carry_d;
                        addr_q      <= addr_q + ADDR_STEP;
                        remaining_q <= remaining_q - SIZE_W'(1);
                        state_q     <= (remaining_q == SIZE_W'(1)) ? DONE : REQ;
                    end
                end
                DONE: begin
                    if (result_rdy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The accumulator doubles as the result register, so it holds from
    // DONE until the next accepted go reloads it.
    assign go_rdy     = (state_q == IDLE);
    assign mem_reqval = (state_q == REQ);
    assign mem_addr   = addr_q;
    assign result_val = (state_q == DONE);
    assign result     = acc_q;
    assign ovf        = ovf_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_reduce_xcel.sv
// Directed and randomized bench for reduce_xcel with a queue-free arithmetic
// reference model of each reduction mode.
module tb_reduce_xcel;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go_val = 1'b0;
    logic        go_rdy;
    logic [15:0] go_base = '0;
    logic [6:0]  go_size = '0;
    logic [1:0]  go_mode = '0;
    logic        mem_reqval;
    logic        mem_reqrdy = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_respval = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        result_val;
    logic        result_rdy = 1'b0;
    logic [31:0] result;
    logic        ovf;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [31:0] mem_words [0:127];

    reduce_xcel dut (
        .clk         (clk),
        .rst         (rst),
        .go_val      (go_val),
        .go_rdy      (go_rdy),
        .go_base     (go_base),
        .go_size     (go_size),
        .go_mode     (go_mode),
        .mem_reqval  (mem_reqval),
        .mem_reqrdy  (mem_reqrdy),
        .mem_addr    (mem_addr),
        .mem_respval (mem_respval),
        .mem_rdata   (mem_rdata),
        .result_val  (result_val),
        .result_rdy  (result_rdy),
        .result      (result),
        .ovf         (ovf),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: reduce the first n words with plain arithmetic on a 64-bit total.
    task automatic model(input logic [1:0] mode, input int n,
                         output logic [31:0] r, output logic o);
        longint unsigned total = 0;
        logic [31:0] mn = 32'hFFFF_FFFF;
        logic [31:0] mx = 32'h0;
        logic [31:0] x  = 32'h0;
        for (int i = 0; i < n; i++) begin
            total += longint'(mem_words[i]);
            if (mem_words[i] < mn) mn = mem_words[i];
            if (mem_words[i] > mx) mx = mem_words[i];
            x ^= mem_words[i];
        end
        o = 1'b0;
        case (mode)
            2'd0: begin
                o = (total > 64'hFFFF_FFFF);
`ifdef REDUCE_XCEL_SAT_EN
                r = o ? 32'hFFFF_FFFF : total[31:0];
`else
                r = total[31:0];
`endif
            end
            2'd1:    r = mn;
            2'd2:    r = mx;
            default: r = x;
        endcase
    endtask

    task automatic run_job(input string tag, input logic [15:0] base, input int n,
                           input logic [1:0] mode, input int req_stall,
                           input int resp_delay, input int hold);
        logic [31:0] exp_res;
        logic        exp_ovf;
        logic [15:0] exp_addr;
        int          t0;
        model(mode, n, exp_res, exp_ovf);
        chk($sformatf("%s.go_rdy", tag), go_rdy, 1);
        go_val = 1'b1; go_base = base; go_size = 7'(n); go_mode = mode;
        tick();
        t0 = cyc;
        go_val = 1'b0; go_base = 16'($urandom); go_size = 7'($urandom); go_mode = 2'($urandom);
        if (n == 0) chk($sformatf("%s.noreq", tag), mem_reqval, 0);
        for (int i = 0; i < n; i++) begin
            exp_addr = base + 16'(4 * i);
            chk($sformatf("%s.reqval%0d", tag, i), mem_reqval, 1);
            chk($sformatf("%s.addr%0d", tag, i), mem_addr, exp_addr);
            for (int s = 0; s < req_stall; s++) begin
                mem_reqrdy = 1'b0; mem_respval = 1'b1; mem_rdata = $urandom;
                tick();
                chk($sformatf("%s.stall_val%0d", tag, i), mem_reqval, 1);
                chk($sformatf("%s.stall_addr%0d", tag, i), mem_addr, exp_addr);
            end
            mem_respval = 1'b0;
            mem_reqrdy = 1'b1;
            tick();
            mem_reqrdy = 1'b0;
            for (int d = 0; d < resp_delay; d++) begin
                tick();
                chk($sformatf("%s.wait%0d", tag, i), mem_reqval, 0);
            end
            if (i == n - 1) chk($sformatf("%s.early_res", tag), result_val, 0);
            mem_respval = 1'b1; mem_rdata = mem_words[i];
            tick();
            mem_respval = 1'b0; mem_rdata = $urandom;
        end
        if (req_stall == 0 && resp_delay == 0) chk($sformatf("%s.latency", tag), cyc - t0, 2 * n);
        chk($sformatf("%s.result_val", tag), result_val, 1);
        chk($sformatf("%s.result", tag), result, exp_res);
        chk($sformatf("%s.ovf", tag), ovf, exp_ovf);
        for (int h = 0; h < hold; h++) begin
            result_rdy = 1'b0;
            go_val = 1'b1; go_size = 7'd1; go_mode = 2'($urandom);
            tick();
            go_val = 1'b0;
            chk($sformatf("%s.hold_val", tag), result_val, 1);
            chk($sformatf("%s.hold_res", tag), result, exp_res);
            chk($sformatf("%s.hold_gordy", tag), go_rdy, 0);
        end
        result_rdy = 1'b1;
        tick();
        result_rdy = 1'b0;
        chk($sformatf("%s.post_val", tag), result_val, 0);
        chk($sformatf("%s.post_gordy", tag), go_rdy, 1);
        chk($sformatf("%s.post_res", tag), result, exp_res);
        chk($sformatf("%s.post_ovf", tag), ovf, exp_ovf);
        $display("job %s: mode=%0d size=%0d result=%08h ovf=%0b expected %08h/%0b",
                 tag, mode, n, result, ovf, exp_res, exp_ovf);
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst.go_rdy", go_rdy, 1);
        chk("rst.reqval", mem_reqval, 0);
        chk("rst.result_val", result_val, 0);
        chk("rst.busy", busy, 0);
        chk("rst.result", result, 0);
        chk("rst.ovf", ovf, 0);
        chk("rst.addr", mem_addr, 0);

        mem_words[0] = 1; mem_words[1] = 2; mem_words[2] = 3; mem_words[3] = 4;
        run_job("sum_basic", 16'h0100, 4, 2'd0, 0, 0, 0);
        chk("sum_basic.ten", result, 10);

        run_job("min_size0", 16'h0040, 0, 2'd1, 0, 0, 0);
        chk("min_size0.ones", result, 32'hFFFF_FFFF);

        mem_words[0] = 5; mem_words[1] = 32'h8000_0000; mem_words[2] = 7;
        run_job("max_stall", 16'h0300, 3, 2'd2, 3, 2, 0);

        mem_words[0] = 32'hFFFF_FFFF; mem_words[1] = 2;
        run_job("overflow", 16'h0500, 2, 2'd0, 0, 0, 0);

        mem_words[0] = 7; mem_words[1] = 9;
        run_job("addr_wrap", 16'hFFFC, 2, 2'd0, 0, 1, 0);

        // Reset in RESP of word 2 of 4, with a response arriving on the same edge.
        mem_words[0] = 1; mem_words[1] = 2; mem_words[2] = 3; mem_words[3] = 4;
        go_val = 1'b1; go_base = 16'h0200; go_size = 7'd4; go_mode = 2'd0;
        tick();
        go_val = 1'b0;
        mem_reqrdy = 1'b1; tick(); mem_reqrdy = 1'b0;
        mem_respval = 1'b1; mem_rdata = mem_words[0]; tick(); mem_respval = 1'b0;
        mem_reqrdy = 1'b1; tick(); mem_reqrdy = 1'b0;
        rst = 1'b1; mem_respval = 1'b1; mem_rdata = mem_words[1];
        tick();
        rst = 1'b0; mem_respval = 1'b0;
        chk("midrst.go_rdy", go_rdy, 1);
        chk("midrst.busy", busy, 0);
        chk("midrst.result", result, 0);
        chk("midrst.reqval", mem_reqval, 0);
        chk("midrst.addr", mem_addr, 0);
        $display("reset mid-job: go_rdy=%0b result=%08h", go_rdy, result);

        mem_words[0] = 32'hF0; mem_words[1] = 32'h0F;
        run_job("xor_after_rst", 16'h0020, 2, 2'd3, 0, 0, 0);
        chk("xor_after_rst.ff", result, 32'hFF);

        mem_words[0] = 11; mem_words[1] = 3; mem_words[2] = 200;
        run_job("backpressure", 16'h0400, 3, 2'd1, 1, 1, 5);

        for (int k = 0; k < 8; k++) begin
            int n;
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++)
                mem_words[i] = ($urandom_range(0, 1) == 1) ? $urandom : (32'hFFFF_FF00 | 32'($urandom_range(0, 255)));
            run_job($sformatf("rand%0d", k), 16'($urandom), n, 2'($urandom),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
